// File: rtl/maxpool2d.sv
// ----------------------------------------------------------------------------
// maxpool2d
//   2x2 / stride-2 max-pooling stage for a raster pixel stream with all
//   channels packed in one word. It emits one pooled pixel per complete 2x2
//   block, in raster order, one cycle after the bottom-right pixel of the
//   block is accepted. There is no backpressure.
//
//   The even row of each block pair is reduced horizontally into a half-width
//   line buffer of pair-maxima. The odd row reduces its own pair and merges
//   that result with the stored maximum.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for din_vld & fin_start; other input is ignored
//   RUN   | accepting pixels of the current frame; fin_start restarts it
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   frame_h    in   input frame height, latched with the first pixel
//   frame_w    in   input frame width, latched with the first pixel
//   fin_start  in   marks the first pixel of a frame (qualified by din_vld)
//   din_vld    in   input pixel valid
//   din        in   input pixel, channel c = din[c*DATA_WIDTH +: DATA_WIDTH]
//   fout_start out  marks the first pooled pixel of a frame
//   dout_vld   out  one-cycle pulse per pooled pixel
//   dout       out  pooled pixel; holds its value until the next output
//   fout_end   out  marks the last pooled pixel of a frame
// ----------------------------------------------------------------------------
module maxpool2d #(
    parameter int FRAME_H_MAX = 64,
    parameter int FRAME_W_MAX = 64,
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNELS    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [$clog2(FRAME_H_MAX+1)-1:0]       frame_h,
    input  logic [$clog2(FRAME_W_MAX+1)-1:0]       frame_w,
    input  logic                                   fin_start,
    input  logic                                   din_vld,
    input  logic [CHANNELS*DATA_WIDTH-1:0]         din,
    output logic                                   fout_start,
    output logic                                   dout_vld,
    output logic [CHANNELS*DATA_WIDTH-1:0]         dout,
    output logic                                   fout_end
);

    localparam int HW       = $clog2(FRAME_H_MAX+1);
    localparam int WW       = $clog2(FRAME_W_MAX+1);
    localparam int DW       = CHANNELS*DATA_WIDTH;
    localparam int LB_DEPTH = FRAME_W_MAX/2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Per-channel signed maximum; on a tie either operand is correct.
    function automatic logic [DW-1:0] f_max(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] m;
        m = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if ($signed(a[ch*DATA_WIDTH +: DATA_WIDTH]) >=
                $signed(b[ch*DATA_WIDTH +: DATA_WIDTH]))
                m[ch*DATA_WIDTH +: DATA_WIDTH] = a[ch*DATA_WIDTH +: DATA_WIDTH];
            else
                m[ch*DATA_WIDTH +: DATA_WIDTH] = b[ch*DATA_WIDTH +: DATA_WIDTH];
        end
        return m;
    endfunction

    state_t          r_state;
    logic [HW-1:0]   r_frame_h;
    logic [WW-1:0]   r_frame_w;
    logic [HW-1:0]   r_row;
    logic [WW-1:0]   r_col;
    logic [DW-1:0]   r_hold;
    logic [DW-1:0]   r_lbuf [LB_DEPTH];

    logic [DW-1:0]   r_dout;
    logic            r_dout_vld;
    logic            r_fout_start;
    logic            r_fout_end;

    logic            w_start;
    logic            w_acc;
    logic [HW-1:0]   w_fh;
    logic [WW-1:0]   w_fw;
    logic [HW-1:0]   w_row;
    logic [WW-1:0]   w_col;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_emit;
    logic            w_first_blk;
    logic            w_last_blk;
    logic [LB_AW-1:0] w_lb_idx;
    logic [DW-1:0]   w_pair_max;
    logic [DW-1:0]   w_quad_max;

    // A start pixel is always position (0,0) of a frame with the dimensions
    // presented alongside it, whether we are idle or restarting mid-frame.
    // Muxing the coordinates here lets the start pixel be processed in the
    // same cycle it arrives, so back-to-back frames need no bubble.
    assign w_start    = din_vld & fin_start;
    assign w_acc      = din_vld & (fin_start | (r_state == S_RUN));
    assign w_fh       = w_start ? frame_h : r_frame_h;
    assign w_fw       = w_start ? frame_w : r_frame_w;
    assign w_row      = w_start ? '0 : r_row;
    assign w_col      = w_start ? '0 : r_col;

    assign w_col_last = (w_col == w_fw - WW'(1));
    assign w_row_last = (w_row == w_fh - HW'(1));

    // Only (odd,odd) positions produce output. An odd trailing row or
    // column is always at an even index, so it is dropped naturally.
    assign w_emit      = w_acc & w_row[0] & w_col[0];
    assign w_first_blk = (w_row == HW'(1)) && (w_col == WW'(1));
    assign w_last_blk  = (w_row == {w_fh[HW-1:1], 1'b0} - HW'(1)) &&
                         (w_col == {w_fw[WW-1:1], 1'b0} - WW'(1));

    assign w_lb_idx   = w_col[LB_AW:1];
    assign w_pair_max = f_max(r_hold, din);
    assign w_quad_max = f_max(w_pair_max, r_lbuf[w_lb_idx]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_frame_h    <= '0;
            r_frame_w    <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_hold       <= '0;
            r_dout       <= '0;
            r_dout_vld   <= 1'b0;
            r_fout_start <= 1'b0;
            r_fout_end   <= 1'b0;
        end else begin
            r_dout_vld   <= 1'b0;
            r_fout_start <= 1'b0;
            r_fout_end   <= 1'b0;

            if (w_start) begin
                r_frame_h <= frame_h;
                r_frame_w <= frame_w;
            end

            if (w_acc) begin
                if (!w_col[0])
                    r_hold <= din;

                if (w_emit) begin
                    r_dout       <= w_quad_max;
                    r_dout_vld   <= 1'b1;
                    r_fout_start <= w_first_blk;
                    r_fout_end   <= w_last_blk;
                end

                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : w_row + HW'(1);
                end else begin
                    r_col <= w_col + WW'(1);
                    r_row <= w_row;
                end

                r_state <= (w_col_last && w_row_last) ? S_IDLE : S_RUN;
            end
        end
    end

    // Line buffer is not reset: every entry is written on an even row
    // before the odd row below it reads it.
    always_ff @(posedge clk) begin
        if (w_acc && !w_row[0] && w_col[0])
            r_lbuf[w_lb_idx] <= w_pair_max;
    end

    assign dout       = r_dout;
    assign dout_vld   = r_dout_vld;
    assign fout_start = r_fout_start;
    assign fout_end   = r_fout_end;

endmodule

// File: tb/tb_maxpool2d.sv
// ----------------------------------------------------------------------------
// tb_maxpool2d
//   Self-checking bench for maxpool2d using the default parameters. A
//   frame-level reference model stores each accepted pixel at
//   (index / width, index % width). When a pixel completes a 2x2 block, the
//   model queues the block maximum, its start/end flags and the cycle in
//   which it must appear. A monitor on the falling edge checks every
//   dout_vld against that queue.
// ----------------------------------------------------------------------------
module tb_maxpool2d;

    localparam int DWID = 16;
    localparam int CH   = 8;
    localparam int W    = CH*DWID;
    localparam int HW   = 7;
    localparam int WW   = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [HW-1:0] frame_h = '0;
    logic [WW-1:0] frame_w = '0;
    logic          fin_start = 1'b0;
    logic          din_vld = 1'b0;
    logic [W-1:0]  din = '0;
    logic          fout_start;
    logic          dout_vld;
    logic [W-1:0]  dout;
    logic          fout_end;

    maxpool2d dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_h    (frame_h),
        .frame_w    (frame_w),
        .fin_start  (fin_start),
        .din_vld    (din_vld),
        .din        (din),
        .fout_start (fout_start),
        .dout_vld   (dout_vld),
        .dout       (dout),
        .fout_end   (fout_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         st;
        logic         en;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [DWID-1:0] a, b, c, d, e;
    } tv_t;

    exp_t            exp_q[$];
    logic [DWID-1:0] got_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int n_fstart = 0;

    logic [W-1:0] m_pix [64][64];
    bit m_active = 0;
    int m_fh = 0, m_fw = 0, m_n = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] max4(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] m;
        int v;
        m = '0;
        for (int k = 0; k < CH; k++) begin
            v = int'($signed(a[k*DWID +: DWID]));
            if (int'($signed(b[k*DWID +: DWID])) > v) v = int'($signed(b[k*DWID +: DWID]));
            if (int'($signed(c[k*DWID +: DWID])) > v) v = int'($signed(c[k*DWID +: DWID]));
            if (int'($signed(d[k*DWID +: DWID])) > v) v = int'($signed(d[k*DWID +: DWID]));
            m[k*DWID +: DWID] = DWID'(v);
        end
        return m;
    endfunction

    task automatic model_accept(input logic vld, input logic st, input logic [W-1:0] d,
                                input int fh, input int fw);
        int r, c;
        exp_t e;
        if (vld && st) begin
            m_active = 1;
            m_fh = fh;
            m_fw = fw;
            m_n = 0;
        end
        if (vld && m_active) begin
            r = m_n / m_fw;
            c = m_n % m_fw;
            m_pix[r][c] = d;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e.data = max4(m_pix[r-1][c-1], m_pix[r-1][c], m_pix[r][c-1], m_pix[r][c]);
                e.st   = (r == 1) && (c == 1);
                e.en   = (r == (m_fh/2)*2 - 1) && (c == (m_fw/2)*2 - 1);
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
            m_n++;
            if (m_n == m_fh*m_fw) m_active = 0;
        end
    endtask

    // Present one input cycle; the DUT samples it on the next rising edge.
    task automatic send(input logic vld, input logic st, input logic [W-1:0] d,
                        input int fh, input int fw);
        din_vld   = vld;
        fin_start = st;
        din       = d;
        frame_h   = HW'(fh);
        frame_w   = WW'(fw);
        @(posedge clk);
        #1;
        model_accept(vld, st, d, fh, fw);
        din_vld   = 1'b0;
        fin_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, '0, 0, 0);
    endtask

    function automatic logic [W-1:0] rep(input int v);
        logic [DWID-1:0] s;
        s = DWID'(v);
        return {CH{s}};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < CH; k++) w[k*DWID +: DWID] = DWID'($urandom);
        return w;
    endfunction

    task automatic check_got(input string name, input int exp_vals[$]);
        check({name, "_count"}, W'(got_q.size()), W'(exp_vals.size()));
        for (int i = 0; i < exp_vals.size() && i < got_q.size(); i++)
            check(name, W'(got_q[i]), W'(DWID'(exp_vals[i])));
    endtask

    // Output monitor, sampling half a cycle away from the active edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (dout_vld) begin
            n_out++;
            if (fout_start) n_fstart++;
            got_q.push_back(dout[DWID-1:0]);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: dout_vld=1 dout %h, none expected", dout);
            end else begin
                e = exp_q.pop_front();
                check("dout", dout, e.data);
                check("fout_start", W'(fout_start), W'(e.st));
                check("fout_end", W'(fout_end), W'(e.en));
                check("out_cycle", W'(cyc), W'(e.cyc));
            end
        end else if (fout_start || fout_end) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_flag_no_vld: fout_start=%0b fout_end=%0b with dout_vld=0",
                     fout_start, fout_end);
        end
    end

    initial begin
        tv_t tv[8];
        int fh, fw;
        int base_out, base_fs;

        tv[0] = '{16'(-3),     16'(-8),     16'(-1), 16'(-32768), 16'(-1)};
        tv[1] = '{16'(1),      16'(2),      16'(3),  16'(4),      16'(4)};
        tv[2] = '{16'(7),      16'(7),      16'(7),  16'(7),      16'(7)};
        tv[3] = '{16'(-32768), 16'(-32768), 16'(-32768), 16'(-32768), 16'(-32768)};
        tv[4] = '{16'(32767),  16'(-32768), 16'(0),  16'(-1),     16'(32767)};
        tv[5] = '{16'(-5),     16'(-2),     16'(-9), 16'(-2),     16'(-2)};
        tv[6] = '{16'(100),    16'(-100),   16'(200), 16'(-200),  16'(200)};
        tv[7] = '{16'(-1),     16'(0),      16'(-1), 16'(-1),     16'(0)};

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, '0);
        check("rst_dout_vld", W'(dout_vld), '0);
        check("rst_fout_start", W'(fout_start), '0);
        check("rst_fout_end", W'(fout_end), '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle: fin_start without din_vld, and din_vld without fin_start, ignored
        send(1'b0, 1'b1, rep(9), 2, 2);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, rep(50 + i), 2, 2);
        idle(3);

        // Table of 2x2 frames, back to back
        for (int t = 0; t < 8; t++) begin
            send(1'b1, 1'b1, {CH{tv[t].a}}, 2, 2);
            send(1'b1, 1'b0, {CH{tv[t].b}}, 2, 2);
            send(1'b1, 1'b0, {CH{tv[t].c}}, 2, 2);
            send(1'b1, 1'b0, {CH{tv[t].d}}, 2, 2);
            check("tbl_dout", dout, {CH{tv[t].e}});
            check("tbl_vld_start_end", W'({dout_vld, fout_start, fout_end}), W'(3'b111));
        end
        idle(2);

        // 4x4 ramp
        got_q.delete();
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, rep(i), 4, 4);
        idle(2);
        check_got("ramp4x4", '{5, 7, 13, 15});

        // 5 rows x 3 cols: column 2 and row 4 dropped, then a frame right after
        got_q.delete();
        for (int i = 0; i < 15; i++) send(1'b1, i == 0, rep(i), 5, 3);
        for (int i = 0; i < 4; i++) send(1'b1, i == 0, rep(20 + i), 2, 2);
        idle(2);
        check_got("odd5x3", '{4, 10, 23});

        // 4x4 with random gaps and independent per-channel ramps
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] w;
            idle($urandom_range(0, 3));
            for (int k = 0; k < CH; k++) w[k*DWID +: DWID] = DWID'(k*1000 - 3000 + i*(k+1));
            send(1'b1, i == 0, w, 4, 4);
        end
        idle(2);

        // Restart at pixel (1,0)
        got_q.delete();
        base_out = n_out;
        base_fs  = n_fstart;
        for (int i = 0; i < 4; i++) send(1'b1, i == 0, rep(i), 4, 4);
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, rep(100 + i), 4, 4);
        idle(2);
        check("restart_outputs", W'(n_out - base_out), W'(4));
        check("restart_fstarts", W'(n_fstart - base_fs), W'(1));
        check_got("restart", '{105, 107, 113, 115});

        // Asynchronous reset right after pixel (1,1) produced an output
        for (int i = 0; i < 6; i++) send(1'b1, i == 0, rep(i), 4, 4);
        check("pre_rst_vld", W'(dout_vld), W'(1));
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_dout", dout, '0);
        check("async_rst_vld_flags", W'({dout_vld, fout_start, fout_end}), '0);
        m_active = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, rep(6 + i), 4, 4);
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, rnd_word(), 4, 4);
        idle(2);

        // Random frames, sizes including degenerate 1-wide/1-high
        for (int f = 0; f < 24; f++) begin
            fh = $urandom_range(1, 9);
            fw = $urandom_range(1, 9);
            for (int i = 0; i < fh*fw; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(1'b1, i == 0, rnd_word(), fh, fw);
            end
        end

        // Full-size frame exercising the whole line buffer
        for (int i = 0; i < 64*64; i++) send(1'b1, i == 0, rnd_word(), 64, 64);
        idle(4);

        check("pending_outputs", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
